rx_chan_sequencer: RTL and testbench

Per-sample channel sequencer for the receive datapath. On each decimated sample strobe it latches the I/Q words of all enabled DDC channels, then serialises them as I/Q pairs, lowest channel first, into the single RX FIFO write port. The FIFO's full flag stalls it, and it flags a sticky overrun when a strobe arrives before the previous frame has drained. It sits between the strobe-driven channel outputs and the RX FIFO and drives the channel-select index for debug and muxing.

---
 rtl/rx_chan_sequencer.sv | 150 +++++++++++++++
 tb/tb_rx_chan_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chan_sequencer.sv
// rx_chan_sequencer
//   Latches the I/Q words of all enabled DDC channels on each accepted
//   sample strobe. It then writes them as I/Q pairs into the RX FIFO,
//   lowest channel first, one word per cycle, and pauses while the FIFO is full.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   enable              gates strobe acceptance only
//   channels[2:0]       active channels minus one (saturates at NCH_MAX-1)
//   strobe              one-cycle sample strobe
//   din                 packed channel samples, channel k = {Q, I}
//   fifo_full           RX FIFO full; suppresses the write
//   clr_overrun         synchronous clear of the overrun flag
//   wr_data, wr_en      FIFO write port (combinational from state + fifo_full)
//   sof                 start of frame, marks the channel-0 I write
//   sel[2:0]            channel index of the current word
//   busy                frame in progress
//   overrun             sticky: a strobe arrived before the frame drained
module rx_chan_sequencer #(
    parameter int unsigned NCH_MAX = 4,
    parameter int unsigned DW      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [2:0]                channels,
    input  logic                      strobe,
    input  logic [2*NCH_MAX*DW-1:0]   din,
    input  logic                      fifo_full,
    input  logic                      clr_overrun,
    output logic [DW-1:0]             wr_data,
    output logic                      wr_en,
    output logic                      sof,
    output logic [2:0]                sel,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned HW    = 2 * NCH_MAX * DW;
    localparam int unsigned NWORD = 2 * NCH_MAX;
    localparam int unsigned IDXW  = (NWORD > 1) ? $clog2(NWORD) : 1;
    localparam logic [2:0]  LAST_MAX = 3'(NCH_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [2:0]      last_ch_q, last_ch_d;
    logic [2:0]      sel_q, sel_d;
    logic            overrun_q, overrun_d;

    logic            last_word;
    logic            accept;
    logic            req;
    logic [IDXW-1:0] word_idx;
    logic [DW-1:0]   words [NWORD];

    // Unpack the held frame into one entry per FIFO word, in send order.
    for (genvar g = 0; g < NWORD; g++) begin : g_words
        assign words[g] = hold_q[g*DW +: DW];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            last_ch_q <= '0;
            sel_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            last_ch_q <= last_ch_d;
            sel_q     <= sel_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic and acceptance/overrun decisions.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_ch_d = last_ch_q;
        sel_d     = sel_q;
        overrun_d = overrun_q;

        // The final Q write frees the sequencer in the same cycle, so a
        // coincident strobe can chain a new frame without a gap.
        last_word = (state_q == SEND_Q) && (sel_q == last_ch_q) && !fifo_full;
        req       = strobe && enable;
        accept    = req && ((state_q == IDLE) || last_word);

        case (state_q)
            SEND_I: begin
                if (!fifo_full) begin
                    state_d = SEND_Q;
                end
            end
            SEND_Q: begin
                if (!fifo_full) begin
                    if (sel_q == last_ch_q) begin
                        state_d = IDLE;
                    end else begin
                        sel_d   = sel_q + 3'd1;
                        state_d = SEND_I;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            hold_d    = din;
            last_ch_d = (channels > LAST_MAX) ? LAST_MAX : channels;
            sel_d     = 3'd0;
            state_d   = SEND_I;
        end

        // Set has priority over clear.
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (req && !accept) begin
            overrun_d = 1'b1;
        end
    end

    // Output decode: word index is (2*sel + Q); IDLE presents channel-0 I.
    always_comb begin
        word_idx = IDXW'({sel_q, (state_q == SEND_Q)});
        if (state_q == IDLE) begin
            word_idx = '0;
        end
        wr_data = words[word_idx];
        busy    = (state_q != IDLE);
        wr_en   = busy && !fifo_full;
        sof     = wr_en && (state_q == SEND_I) && (sel_q == 3'd0);
    end

    assign sel     = sel_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rx_chan_sequencer.sv
module tb_rx_chan_sequencer;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [2:0]           channels;
    logic                 strobe;
    logic [2*NCH*DW-1:0]  din;
    logic                 fifo_full;
    logic                 clr_overrun;
    logic [DW-1:0]        wr_data;
    logic                 wr_en;
    logic                 sof;
    logic [2:0]           sel;
    logic                 busy;
    logic                 overrun;

    int n_chk = 0;
    int n_err = 0;

    rx_chan_sequencer #(.NCH_MAX(NCH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .channels(channels),
        .strobe(strobe), .din(din), .fifo_full(fifo_full),
        .clr_overrun(clr_overrun), .wr_data(wr_data), .wr_en(wr_en),
        .sof(sof), .sel(sel), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model: queue of words still owed to the FIFO
    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  ch;
        logic        sof;
    } word_t;

    word_t        exp_q[$];
    logic [15:0]  idle_i0;
    logic [2:0]   idle_sel;
    logic         m_ovr;

    task automatic model_reset();
        exp_q.delete();
        idle_i0  = '0;
        idle_sel = '0;
        m_ovr    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic        b_e;
        logic [15:0] d_e;
        logic [2:0]  s_e;
        logic        f_e;
        b_e = (exp_q.size() != 0);
        d_e = b_e ? exp_q[0].data : idle_i0;
        s_e = b_e ? exp_q[0].ch   : idle_sel;
        f_e = b_e && !fifo_full && exp_q[0].sof;
        chk({tag, "_busy"},    32'(busy),    32'(b_e));
        chk({tag, "_wr_en"},   32'(wr_en),   32'(b_e && !fifo_full));
        chk({tag, "_sof"},     32'(sof),     32'(f_e));
        chk({tag, "_sel"},     32'(sel),     32'(s_e));
        chk({tag, "_wr_data"}, 32'(wr_data), 32'(d_e));
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit wr, acc;
        int n;
        wr  = (exp_q.size() != 0) && !fifo_full;
        acc = strobe && enable && ((exp_q.size() == 0) || (exp_q.size() == 1 && wr));
        if (wr) begin
            idle_sel = exp_q[0].ch;
            void'(exp_q.pop_front());
        end
        if (clr_overrun) m_ovr = 1'b0;
        if (strobe && enable && !acc) m_ovr = 1'b1;
        if (acc) begin
            n = (channels > 3'd3) ? 4 : int'(channels) + 1;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{data: din[2*k*DW +: DW], ch: 3'(k), sof: (k == 0)});
                exp_q.push_back('{data: din[(2*k+1)*DW +: DW], ch: 3'(k), sof: 1'b0});
            end
            idle_i0 = din[DW-1:0];
        end
    endtask

    task automatic cyc(input string tag, input logic stb, input logic en,
                       input logic full, input logic clr);
        strobe = stb; enable = en; fifo_full = full; clr_overrun = clr;
        @(negedge clk);
        check_outputs(tag);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        strobe = 0; enable = 0; fifo_full = 0; clr_overrun = 0;
        reset = 1'b1;
        #1;
        chk("rst_wr_en",   32'(wr_en),   0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_sof",     32'(sof),     0);
        chk("rst_sel",     32'(sel),     0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_overrun", 32'(overrun), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [2*NCH*DW-1:0] pattern();
        logic [2*NCH*DW-1:0] d;
        for (int k = 0; k < NCH; k++) begin
            d[2*k*DW +: DW]     = {4'h0, 4'(k), 8'h10};
            d[(2*k+1)*DW +: DW] = {4'h0, 4'(k), 8'h20};
        end
        return d;
    endfunction

    // ---------------- directed table
    typedef struct {
        logic        stb;
        logic        en;
        logic        full;
        logic        wen;
        logic [15:0] data;
        logic        sof;
        logic [2:0]  sel;
        logic        busy;
    } vec_t;

    function automatic vec_t mk(logic stb, logic en, logic full, logic wen,
                                logic [15:0] data, logic sof, logic [2:0] sel, logic busy);
        vec_t v;
        v.stb = stb; v.en = en; v.full = full; v.wen = wen;
        v.data = data; v.sof = sof; v.sel = sel; v.busy = busy;
        return v;
    endfunction

    vec_t tbl[25];

    initial begin
        reset = 1'b1; strobe = 0; enable = 0; fifo_full = 0; clr_overrun = 0;
        channels = 3'd3; din = pattern();
        #2;
        do_reset();

        // Single frame, then a frame with a 3-cycle stall on ch1 Q, then enable low.
        tbl[0]  = mk(1,1,0, 0,16'h0000,0,0,0);
        tbl[1]  = mk(0,1,0, 1,16'h0010,1,0,1);
        tbl[2]  = mk(0,1,0, 1,16'h0020,0,0,1);
        tbl[3]  = mk(0,1,0, 1,16'h0110,0,1,1);
        tbl[4]  = mk(0,1,0, 1,16'h0120,0,1,1);
        tbl[5]  = mk(0,1,0, 1,16'h0210,0,2,1);
        tbl[6]  = mk(0,1,0, 1,16'h0220,0,2,1);
        tbl[7]  = mk(0,1,0, 1,16'h0310,0,3,1);
        tbl[8]  = mk(0,1,0, 1,16'h0320,0,3,1);
        tbl[9]  = mk(0,1,0, 0,16'h0010,0,3,0);
        tbl[10] = mk(1,1,0, 0,16'h0010,0,3,0);
        tbl[11] = mk(0,1,0, 1,16'h0010,1,0,1);
        tbl[12] = mk(0,1,0, 1,16'h0020,0,0,1);
        tbl[13] = mk(0,1,0, 1,16'h0110,0,1,1);
        tbl[14] = mk(0,1,1, 0,16'h0120,0,1,1);
        tbl[15] = mk(0,1,1, 0,16'h0120,0,1,1);
        tbl[16] = mk(0,1,1, 0,16'h0120,0,1,1);
        tbl[17] = mk(0,1,0, 1,16'h0120,0,1,1);
        tbl[18] = mk(0,1,0, 1,16'h0210,0,2,1);
        tbl[19] = mk(0,1,0, 1,16'h0220,0,2,1);
        tbl[20] = mk(0,1,0, 1,16'h0310,0,3,1);
        tbl[21] = mk(0,1,0, 1,16'h0320,0,3,1);
        tbl[22] = mk(0,1,0, 0,16'h0010,0,3,0);
        tbl[23] = mk(1,0,0, 0,16'h0010,0,3,0);
        tbl[24] = mk(0,1,0, 0,16'h0010,0,3,0);

        for (int i = 0; i < 25; i++) begin
            strobe = tbl[i].stb; enable = tbl[i].en; fifo_full = tbl[i].full;
            clr_overrun = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_en", i),   32'(wr_en),   32'(tbl[i].wen));
            chk($sformatf("tbl%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_sof", i),     32'(sof),     32'(tbl[i].sof));
            chk($sformatf("tbl%0d_sel", i),     32'(sel),     32'(tbl[i].sel));
            chk($sformatf("tbl%0d_busy", i),    32'(busy),    32'(tbl[i].busy));
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 0);
            @(posedge clk);
            #1;
        end

        // Periodic divide-by-64: 100 frames of 8 words, then 20 frames of 2 words.
        do_reset();
        channels = 3'd3;
        for (int f = 0; f < 120; f++) begin
            if (f == 100) channels = 3'd0;
            din = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < 64; c++) cyc("per64", (c == 0), 1, 0, 0);
        end
        chk("per64_no_overrun", 32'(overrun), 0);

        // Back-to-back: channels=1, period 4 gives gapless writes.
        channels = 3'd1;
        for (int c = 0; c < 80; c++) begin
            if (c % 4 == 0) din = {$urandom, $urandom, $urandom, $urandom};
            cyc("p4", (c % 4 == 0), 1, 0, 0);
        end
        chk("p4_no_overrun", 32'(overrun), 0);

        // Period 3: every other strobe is dropped, then overrun is cleared.
        for (int c = 0; c < 30; c++) begin
            if (c % 3 == 0) din = {$urandom, $urandom, $urandom, $urandom};
            cyc("p3", (c % 3 == 0), 1, 0, 0);
        end
        chk("p3_overrun_set", 32'(overrun), 1);
        for (int c = 0; c < 6; c++) cyc("p3_drain", 0, 1, 0, 0);
        cyc("clr", 0, 1, 0, 1);
        chk("clr_overrun", 32'(overrun), 0);
        // Set wins over a coincident clear.
        cyc("sc_a", 1, 1, 0, 0);
        cyc("sc_b", 1, 1, 0, 1);
        chk("set_beats_clr", 32'(overrun), 1);
        for (int c = 0; c < 6; c++) cyc("sc_drain", 0, 1, 0, (c == 5));

        // Config sampling: channels drops to 0 mid-frame.
        channels = 3'd3;
        din = pattern();
        cyc("cfg", 1, 1, 0, 0);
        cyc("cfg", 0, 1, 0, 0);
        channels = 3'd0;
        for (int c = 0; c < 8; c++) cyc("cfg", 0, 1, 0, 0);
        cyc("cfg2", 1, 1, 0, 0);
        for (int c = 0; c < 4; c++) cyc("cfg2", 0, 1, 0, 0);

        // Reset mid-frame after the third write.
        channels = 3'd3;
        din = pattern();
        cyc("mid", 1, 1, 0, 0);
        for (int c = 0; c < 3; c++) cyc("mid", 0, 1, 0, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_busy",  32'(busy),  0);
        chk("mid_rst_sel",   32'(sel),   0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cyc("post", 0, 1, 0, 0);
        cyc("post", 1, 1, 0, 0);
        for (int c = 0; c < 10; c++) cyc("post", 0, 1, 0, 0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            channels = 3'($urandom_range(0, 7));
            cyc("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
